furv_ifetch: RTL and testbench

//  Instruction prefetch stage directly upstream of the furv core. Takes the core's pc, fetches

---
 rtl/furv_ifetch_if.sv | 13 +
 rtl/furv_ifetch.sv | 126 ++++++++++++
 tb/tb_furv_ifetch.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/furv_ifetch_if.sv
// Instruction-memory request/grant/rvalid bus between furv_ifetch (master) and imem (slave).
// Handshake: a request transfers on a cycle where req && gnt; addr is held while req waits
// for gnt. rvalid answers granted requests strictly in grant order, at least one cycle later.
interface furv_ifetch_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/furv_ifetch.sv
// Sequential instruction prefetcher with a small FIFO and redirect-on-branch.
// Optional FURV_IFETCH_PERF_EN adds consume/redirect/stall event counters.
module furv_ifetch #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pc_i,
    input  logic                 req_i,
    output logic [31:0]          instr_o,
    output logic                 valid_o,
`ifdef FURV_IFETCH_PERF_EN
    output logic [31:0]          perf_consume,
    output logic [31:0]          perf_redirect,
    output logic [31:0]          perf_stall,
`endif
    furv_ifetch_if.master        imem
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   fifo_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [OW-1:0] live_cnt;
    logic [OW-1:0] drop_cnt;
    logic [31:0]   head_addr;
    logic [31:0]   fetch_addr;

    logic          pc_match;
    logic          redirect;
    logic          consume;
    logic          grant;
    logic          push;
    logic          drop_resp;
    logic [31:0]   fill_level;
    logic [31:0]   inflight;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^pc_i[1:0];

    always_comb begin
        pc_match   = (pc_i[31:2] == head_addr[31:2]);
        redirect   = req_i && !pc_match;
        valid_o    = (count != '0) && pc_match;
        consume    = req_i && valid_o;
        instr_o    = (count != '0) ? fifo_mem[rd_ptr] : 32'h0;
        // Credits cover both the FIFO slots and the outstanding-request limit, so a
        // returning live word always has room.
        fill_level = 32'(count) + 32'(live_cnt);
        inflight   = 32'(live_cnt) + 32'(drop_cnt);
        imem.req   = !rst && !redirect && (fill_level < DEPTH) && (inflight < MAX_OUTSTANDING);
        imem.addr  = fetch_addr;
        grant      = imem.req && imem.gnt;
        // Responses are discarded while older redirected requests are still draining,
        // and also in the redirect cycle itself (they belong to the old stream).
        push       = imem.rvalid && (drop_cnt == '0) && !redirect;
        drop_resp  = imem.rvalid && !push;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            live_cnt   <= '0;
            drop_cnt   <= '0;
            head_addr  <= RESET_PC;
            fetch_addr <= RESET_PC;
        end else if (redirect) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            live_cnt   <= '0;
            drop_cnt   <= drop_cnt + live_cnt + OW'(grant) - OW'(drop_resp);
            head_addr  <= {pc_i[31:2], 2'b00};
            fetch_addr <= {pc_i[31:2], 2'b00};
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (consume) begin
                rd_ptr    <= rd_ptr + PW'(1);
                head_addr <= head_addr + 32'd4;
            end
            if (grant) begin
                fetch_addr <= fetch_addr + 32'd4;
            end
            count    <= count + CW'(push) - CW'(consume);
            live_cnt <= live_cnt + OW'(grant) - OW'(push);
            drop_cnt <= drop_cnt - OW'(drop_resp);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr] <= imem.rdata;
        end
    end

`ifdef FURV_IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_consume  <= '0;
            perf_redirect <= '0;
            perf_stall    <= '0;
        end else begin
            if (consume) begin
                perf_consume <= perf_consume + 32'd1;
            end
            if (redirect) begin
                perf_redirect <= perf_redirect + 32'd1;
            end
            if (req_i && !valid_o && !redirect) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_furv_ifetch.sv
// Bench for furv_ifetch: queue-based stream model plus an in-order random-latency imem.
// Build with FURV_IFETCH_PERF_EN defined to also check the event counters.
module tb_furv_ifetch;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        req_i;
  logic [31:0] instr_o;
  logic        valid_o;
`ifdef FURV_IFETCH_PERF_EN
  logic [31:0] perf_consume, perf_redirect, perf_stall;
`endif

  furv_ifetch_if imem ();

  furv_ifetch #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .pc_i(pc_i),
    .req_i(req_i),
    .instr_o(instr_o),
    .valid_o(valid_o),
`ifdef FURV_IFETCH_PERF_EN
    .perf_consume(perf_consume),
    .perf_redirect(perf_redirect),
    .perf_stall(perf_stall),
`endif
    .imem(imem)
  );

  always #5 clk = ~clk;

  // ---------------- memory, model and logs ----------------
  typedef struct {
    logic [31:0] addr;
    int          ready;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] m_fifo[$];   // words buffered, oldest first
  bit          m_fl[$];     // outstanding requests in order: 1 = live, 0 = to be dropped
  logic [31:0] m_head, m_fetch;
  int          m_cons, m_red, m_stall;

  logic [31:0] grant_log[$];
  logic [31:0] cons_log[$];
  int          cons_cyc[$];
  int          first_valid;
  logic        obs0_valid, obs0_req, last_req;
  logic [31:0] obs0_addr, obs0_instr, last_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic        rst_v;
  int          req_prob, gnt_prob, dmin, dmax, jump_prob;
  bit          low_bits;
  logic [31:0] core_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    m_fifo.delete();
    m_fl.delete();
    m_head = 32'h0;
    m_fetch = 32'h0;
    m_cons = 0;
    m_red = 0;
    m_stall = 0;
    grant_log.delete();
    cons_log.delete();
    cons_cyc.delete();
    first_valid = -1;
    cyc = 0;
  endtask

  // One clock cycle: drive at negedge, compare 1ns later, then advance the model.
  task automatic step();
    logic red, exp_valid, exp_req, cons, gr, tag;
    int live;
    @(negedge clk);
    rst = rst_v;
    if (!rst_v && $urandom_range(0, 99) < jump_prob) begin
      case ($urandom_range(0, 2))
        0: core_pc = $urandom;
        1: core_pc = m_head + {$urandom_range(0, 4), 2'b00};
        default: core_pc = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
      endcase
    end
    req_i = !rst_v && ($urandom_range(0, 99) < req_prob);
    pc_i = low_bits ? {core_pc[31:2], 2'($urandom)} : core_pc;
    imem.gnt = $urandom_range(0, 99) < gnt_prob;
    imem.rvalid = !rst_v && mem_q.size() != 0 && mem_q[0].ready <= cyc;
    imem.rdata = imem.rvalid ? mem_word(mem_q[0].addr) : $urandom;
    #1;
    if (rst) begin
      check("req_in_reset", 32'(imem.req), 32'h0);
      model_reset();
    end else begin
      red = req_i && (pc_i[31:2] != m_head[31:2]);
      exp_valid = m_fifo.size() != 0 && pc_i[31:2] == m_head[31:2];
      live = 0;
      foreach (m_fl[i]) if (m_fl[i]) live++;
      exp_req = !red && (m_fifo.size() + live < DEPTH) && (m_fl.size() < MAX_OUT);
      check("valid_o", 32'(valid_o), 32'(exp_valid));
      check("imem_req", 32'(imem.req), 32'(exp_req));
      check("imem_addr", imem.addr, m_fetch);
      if (exp_valid) check("instr_o", instr_o, m_fifo[0]);
`ifdef FURV_IFETCH_PERF_EN
      check("perf_consume", perf_consume, m_cons);
      check("perf_redirect", perf_redirect, m_red);
      check("perf_stall", perf_stall, m_stall);
`endif
      if (cyc == 0) begin
        obs0_valid = valid_o; obs0_req = imem.req; obs0_addr = imem.addr; obs0_instr = instr_o;
      end
      last_req = imem.req;
      last_addr = imem.addr;
      if (valid_o && first_valid < 0) first_valid = cyc;
      if (req_i && valid_o) begin
        cons_log.push_back(instr_o);
        cons_cyc.push_back(cyc);
      end

      cons = req_i && exp_valid;
      gr = imem.req && imem.gnt;
      m_cons += int'(cons);
      m_red += int'(red);
      m_stall += int'(req_i && !exp_valid && !red);
      if (cons) core_pc = core_pc + 32'd4;
      if (imem.rvalid) begin
        tag = m_fl.pop_front();
        void'(mem_q.pop_front());
        if (tag && !red) begin
          check("fifo_no_overflow", 32'(m_fifo.size() < DEPTH), 32'h1);
          if (cons) void'(m_fifo.pop_front());
          cons = 1'b0;
          m_fifo.push_back(imem.rdata);
        end
      end
      if (gr) begin
        check("outstanding_limit", 32'(m_fl.size() < MAX_OUT), 32'h1);
        grant_log.push_back(imem.addr);
        mem_q.push_back('{addr: imem.addr, ready: cyc + 1 + $urandom_range(dmin, dmax)});
        m_fl.push_back(!red);
      end
      if (red) begin
        m_fifo.delete();
        foreach (m_fl[i]) m_fl[i] = 1'b0;
        m_head = {pc_i[31:2], 2'b00};
        m_fetch = {pc_i[31:2], 2'b00};
      end else begin
        if (cons) void'(m_fifo.pop_front());
        if (cons || (req_i && exp_valid)) m_head = m_head + 32'd4;
        if (gr) m_fetch = m_fetch + 32'd4;
      end
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    step();
    step();
    rst_v = 1'b0;
  endtask

  task automatic set_mode(input int rq, input int gn, input int d0, input int d1,
                          input int jp, input bit lb, input logic [31:0] pc0);
    req_prob = rq; gnt_prob = gn; dmin = d0; dmax = d1; jump_prob = jp; low_bits = lb;
    core_pc = pc0;
  endtask

  initial begin
    rst = 1'b1; req_i = 1'b0; pc_i = 32'h0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;
    set_mode(0, 0, 0, 0, 0, 0, 32'h0);
    model_reset();

    // Zero-wait memory, core at 0: first word on cycle 2, then one per cycle.
    do_reset();
    set_mode(100, 100, 0, 0, 0, 0, 32'h0);
    repeat (6) step();
    check("s1_first_valid_cycle", first_valid, 32'd2);
    check("s1_consumed", cons_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < cons_log.size(); i++) begin
      check("s1_word", cons_log[i], mem_word(32'(4 * i)));
      check("s1_word_cycle", cons_cyc[i], 32'(2 + i));
    end
    check("s1_model_consume", m_cons, 32'd4);
    check("s1_model_stall", m_stall, 32'd2);
    check("s1_model_redirect", m_red, 32'd0);

    // Core idle: prefetch stops after exactly DEPTH grants.
    do_reset();
    set_mode(0, 100, 0, 0, 0, 0, 32'h0);
    repeat (10) step();
    check("rst_valid_o", 32'(obs0_valid), 32'h0);
    check("rst_instr_o", obs0_instr, 32'h0);
    check("rst_imem_addr", obs0_addr, 32'h0);
    check("rst_imem_req", 32'(obs0_req), 32'h1);
    check("s2_grants", grant_log.size(), 32'd4);
    if (grant_log.size() == 4) check("s2_last_addr", grant_log[3], 32'hC);
    check("s2_req_idle", 32'(last_req), 32'h0);

    // Grant withheld: request stays up on a stable address, nothing becomes valid.
    do_reset();
    set_mode(100, 0, 0, 0, 0, 0, 32'h0);
    repeat (6) step();
    check("s4_grants", grant_log.size(), 32'd0);
    check("s4_req_held", 32'(last_req), 32'h1);
    check("s4_addr_held", last_addr, 32'h0);
    check("s4_no_valid", first_valid, 32'hFFFF_FFFF);

    // Slow memory with the core idle: credits bound the outstanding count.
    do_reset();
    set_mode(0, 100, 3, 3, 0, 0, 32'h0);
    repeat (20) step();
    check("s5_grants", grant_log.size(), 32'd4);

    // Redirect near the top of memory: fetch wraps to 0; then reset mid-stream.
    do_reset();
    set_mode(100, 100, 0, 0, 0, 0, 32'hFFFF_FFF8);
    repeat (12) step();
    check("s6_redirects", m_red, 32'd1);
    if (grant_log.size() >= 3) begin
      check("s6_grant0", grant_log[0], 32'hFFFF_FFF8);
      check("s6_grant_wrap", grant_log[2], 32'h0);
    end else check("s6_grant_count", grant_log.size(), 32'd3);
    if (cons_log.size() >= 3) check("s6_word_wrap", cons_log[2], mem_word(32'h0));
    else check("s6_consumed", cons_log.size(), 32'd3);
    rst_v = 1'b1;
    step();
    rst_v = 1'b0;
    set_mode(0, 0, 0, 0, 0, 0, 32'hFFFF_FFF8);
    step();
    check("s6_rst_valid", 32'(obs0_valid), 32'h0);
    check("s6_rst_addr", obs0_addr, 32'h0);

    // Randomised traffic with branches, slow/stalling memory and occasional resets.
    do_reset();
    set_mode(90, 80, 0, 2, 3, 1, 32'h0);
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) begin
        req_prob = $urandom_range(40, 100);
        gnt_prob = $urandom_range(20, 100);
        dmax = $urandom_range(0, 4);
        jump_prob = $urandom_range(0, 8);
      end
      if ($urandom_range(0, 999) < 3) begin
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        core_pc = 32'h0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
